fwd_mux_pipe: RTL and testbench
===============================

FWD_MUX_PIPE -- requirements
Module: fwd_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 64: data width of every input source and of the output.
REQ-002 Parameter NUM_IN, default 3, legal 2..8: number of selectable sources.
REQ-003 Parameter HOLD_ON_ILLEGAL, default 0: 0 = an illegal select loads zero; 1 = an illegal select reloads the current data_out.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous reset, active-low.
REQ-006 Port data_in, input, NUM_IN*WIDTH: flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port sel, input, SEL_W = $clog2(NUM_IN): source index.
REQ-008 Port in_valid, input, 1: data_in and sel are valid this cycle.
REQ-009 Port in_ready, output, 1: the stage accepts an input this cycle.
REQ-010 Port flush, input, 1: discard the registered result.
REQ-011 Port out_valid, output, 1: data_out holds a valid result.
REQ-012 Port out_ready, input, 1: the consumer accepts data_out this cycle.
REQ-013 Port data_out, output, WIDTH: registered selected source.
REQ-014 Port sel_err, output, 1: sticky flag, set on any accepted illegal select.

Function
REQ-015 A transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
REQ-016 in_ready = !out_valid || out_ready. The signal is combinational and does not depend on in_valid.
REQ-017 On a transfer in, data_out loads source sel on the next edge and out_valid becomes 1. Latency is one cycle.
REQ-018 sel >= NUM_IN is illegal.
  - On a transfer in with an illegal select, data_out loads zero (HOLD_ON_ILLEGAL=0) or its current value (HOLD_ON_ILLEGAL=1).
  - out_valid still becomes 1.
  - sel_err sets to 1.
REQ-019 A transfer out with no simultaneous transfer in clears out_valid. data_out holds its value.
REQ-020 A simultaneous transfer in and transfer out loads the new data. out_valid stays 1, giving full throughput with no bubble.
REQ-021 While out_valid && !out_ready, data_out and out_valid are held stable and in_ready is 0.
REQ-022 flush=1 clears out_valid on the next edge.
  - flush overrides any same-cycle transfer in; that input is dropped.
  - data_out is not modified by flush.
REQ-023 flush does not clear sel_err. Only reset clears sel_err.
REQ-024 data_out changes only on a transfer in, and never while out_valid=1 without out_ready=1.

Reset
REQ-025 Asserting rst_n=0 immediately forces out_valid=0, data_out=0 and sel_err=0, including in the middle of a held transfer.
REQ-026 After rst_n deasserts, in_ready=1 on the first cycle.

Configuration
REQ-027 With the macro FWD_MUX_ERR_CNT_EN defined, the block adds output port err_cnt (8 bits).
  - err_cnt is a saturating count of accepted illegal selects: it increments with sel_err set conditions and stops at 255.
  - Reset sets err_cnt to 0; flush does not affect it.
REQ-028 Without FWD_MUX_ERR_CNT_EN, the err_cnt port and its counter logic are absent. All other behaviour is identical.

Structure
REQ-029 Shared package fwd_mux_pkg holds:
  - constants FWD_MUX_WIDTH_DEF=64, FWD_MUX_NUM_IN_DEF=3 and FWD_MUX_ERR_CNT_W=8;
  - the select-encoding constants FWD_SEL_REG=0, FWD_SEL_EX=1 and FWD_SEL_MEM=2 used by the forwarding unit.
REQ-030 Sub-module fwd_mux_sel holds the combinational N-way selector. It has outputs sel_data and sel_illegal. fwd_mux_pipe instantiates it once and holds all sequential logic.

Verification
REQ-031 Default parameters, sources 0x11, 0x22, 0x33, in_valid=1, sel=1, out_ready=1 -> data_out=0x22 and out_valid=1 after one edge.
REQ-032 out_ready=0 with out_valid=1, then a new input with sel=2 -> in_ready=0 and data_out is held. After out_ready=1, 0x33 appears one edge later.
REQ-033 sel=3, HOLD_ON_ILLEGAL=0 -> data_out=0, out_valid=1, sel_err=1. Repeat with HOLD_ON_ILLEGAL=1 and prior data 0x22 -> data_out stays 0x22.
REQ-034 flush=1 together with in_valid=1 and sel=0 -> out_valid=0 next cycle, data_out unchanged, sel_err unchanged.
REQ-035 Back-to-back sel=0,1,2 with out_ready=1 -> outputs 0x11, 0x22, 0x33 on consecutive cycles with no bubble.
REQ-036 With FWD_MUX_ERR_CNT_EN, 300 illegal selects -> err_cnt=255. Then assert rst_n=0 mid-stall -> all outputs read 0 immediately.

Source files
------------

// File: rtl/fwd_mux_pkg.sv
// Shared constants for the forwarding mux pipeline stage and the
// forwarding unit that drives its select.
package fwd_mux_pkg;

    localparam int FWD_MUX_WIDTH_DEF  = 64;
    localparam int FWD_MUX_NUM_IN_DEF = 3;
    localparam int FWD_MUX_ERR_CNT_W  = 8;

    // Forwarding sources as encoded by the forwarding unit
    localparam int FWD_SEL_REG = 0;
    localparam int FWD_SEL_EX  = 1;
    localparam int FWD_SEL_MEM = 2;

    typedef enum logic [1:0] {
        FWD_SRC_REG = 2'(FWD_SEL_REG),
        FWD_SRC_EX  = 2'(FWD_SEL_EX),
        FWD_SRC_MEM = 2'(FWD_SEL_MEM)
    } fwd_src_e;

endpackage

// File: rtl/fwd_mux_sel.sv
// Combinational N-way source selector; flags select values with no
// matching source and returns zero data for them.
module fwd_mux_sel
    import fwd_mux_pkg::*;
#(
    parameter int WIDTH  = FWD_MUX_WIDTH_DEF,
    parameter int NUM_IN = FWD_MUX_NUM_IN_DEF,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        sel_data,
    output logic                    sel_illegal
);

    always_comb begin
        sel_data    = '0;
        sel_illegal = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data    = data_in[k*WIDTH +: WIDTH];
                sel_illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fwd_mux_pipe.sv
// Registered forwarding mux with valid/ready handshake and sticky illegal
// select flag. Define FWD_MUX_ERR_CNT_EN to add the saturating err_cnt port.
module fwd_mux_pipe
    import fwd_mux_pkg::*;
#(
    parameter int WIDTH           = FWD_MUX_WIDTH_DEF,
    parameter int NUM_IN          = FWD_MUX_NUM_IN_DEF,
    parameter int HOLD_ON_ILLEGAL = 0,
    localparam int SEL_W          = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        data_out,
`ifdef FWD_MUX_ERR_CNT_EN
    output logic [FWD_MUX_ERR_CNT_W-1:0] err_cnt,
`endif
    output logic                    sel_err
);

    localparam bit HOLD = (HOLD_ON_ILLEGAL != 0);

    logic [WIDTH-1:0] sel_data_p0;
    logic             sel_illegal_p0;
    logic             accept_p0;
    logic             xfer_out_p0;
    logic [WIDTH-1:0] data_nxt_p0;

    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;
    logic             err_p1;

    function automatic logic [FWD_MUX_ERR_CNT_W-1:0] sat_inc(
        input logic [FWD_MUX_ERR_CNT_W-1:0] v
    );
        return (v == '1) ? v : v + FWD_MUX_ERR_CNT_W'(1);
    endfunction

    // ---- stage p0: select and handshake decode
    fwd_mux_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .data_in     (data_in),
        .sel         (sel),
        .sel_data    (sel_data_p0),
        .sel_illegal (sel_illegal_p0)
    );

    assign in_ready    = !vld_p1 || out_ready;
    assign accept_p0   = in_valid && in_ready && !flush;
    assign xfer_out_p0 = vld_p1 && out_ready;

    always_comb begin
        data_nxt_p0 = sel_data_p0;
        if (sel_illegal_p0) begin
            data_nxt_p0 = HOLD ? data_p1 : '0;
        end
    end

    // ---- stage p1: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            err_p1  <= 1'b0;
        end else begin
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (accept_p0) begin
                vld_p1 <= 1'b1;
            end else if (xfer_out_p0) begin
                vld_p1 <= 1'b0;
            end
            if (accept_p0) begin
                data_p1 <= data_nxt_p0;
            end
            if (accept_p0 && sel_illegal_p0) begin
                err_p1 <= 1'b1;
            end
        end
    end

`ifdef FWD_MUX_ERR_CNT_EN
    logic [FWD_MUX_ERR_CNT_W-1:0] err_cnt_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_p1 <= '0;
        end else if (accept_p0 && sel_illegal_p0) begin
            err_cnt_p1 <= sat_inc(err_cnt_p1);
        end
    end

    assign err_cnt = err_cnt_p1;
`endif

    assign out_valid = vld_p1;
    assign data_out  = data_p1;
    assign sel_err   = err_p1;

endmodule

// File: tb/tb_fwd_mux_pipe.sv
// Directed bench for fwd_mux_pipe: scoreboard on out transfers of the
// zero-on-illegal instance plus direct checks on flags and a hold-on-illegal twin.
module tb_fwd_mux_pipe;

    localparam int W  = 64;
    localparam int N  = 3;
    localparam int SW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] data_in;
    logic [SW-1:0]  sel;
    logic           in_valid, flush, out_ready;

    logic           in_ready, out_valid, sel_err;
    logic [W-1:0]   data_out;
    logic           h_in_ready, h_out_valid, h_sel_err;
    logic [W-1:0]   h_data_out;
`ifdef FWD_MUX_ERR_CNT_EN
    logic [7:0]     err_cnt, h_err_cnt;
`endif

    logic [63:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fwd_mux_pipe #(.WIDTH(W), .NUM_IN(N), .HOLD_ON_ILLEGAL(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
`ifdef FWD_MUX_ERR_CNT_EN
        .err_cnt   (err_cnt),
`endif
        .sel_err   (sel_err)
    );

    fwd_mux_pipe #(.WIDTH(W), .NUM_IN(N), .HOLD_ON_ILLEGAL(1)) dut_h (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (h_in_ready),
        .flush     (flush),
        .out_valid (h_out_valid),
        .out_ready (out_ready),
        .data_out  (h_data_out),
`ifdef FWD_MUX_ERR_CNT_EN
        .err_cnt   (h_err_cnt),
`endif
        .sel_err   (h_sel_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] s);
        in_valid = v;
        sel      = s;
    endtask

    // Scoreboard monitor: every transfer out must match the next expected word
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_xfer", data_out, 64'hdead_beef);
            end else begin
                chk("sb_data", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        data_in   = {64'h33, 64'h22, 64'h11};
        sel       = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_sel_err", 64'(sel_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // single transfer, sel=1
        out_ready = 1'b1;
        drive(1'b1, 2'd1); exp_q.push_back(64'h22);
        tick();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data", data_out, 64'h22);
        drive(1'b0, 2'd0);
        tick();
        chk("drain_valid_clr", 64'(out_valid), 64'd0);
        chk("drain_data_hold", data_out, 64'h22);

        // back-to-back, no bubble
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, SW'(i));
            exp_q.push_back(64'(8'h11 * (i + 1)));
            tick();
            chk("b2b_valid", 64'(out_valid), 64'd1);
            chk("b2b_data", data_out, 64'(8'h11 * (i + 1)));
        end
        drive(1'b0, 2'd0);
        tick();
        chk("b2b_end_valid", 64'(out_valid), 64'd0);

        // backpressure stall
        out_ready = 1'b0;
        drive(1'b1, 2'd0); exp_q.push_back(64'h11);
        tick();
        chk("stall_load", data_out, 64'h11);
        drive(1'b1, 2'd2);
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_hold_data", data_out, 64'h11);
            chk("stall_hold_valid", 64'(out_valid), 64'd1);
            chk("stall_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        exp_q.push_back(64'h33);
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("release_data", data_out, 64'h33);
        chk("release_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 2'd0);
        tick();
        chk("release_drain", 64'(out_valid), 64'd0);

        // illegal select after 0x22
        drive(1'b1, 2'd1); exp_q.push_back(64'h22);
        tick();
        drive(1'b1, 2'd3); exp_q.push_back(64'h0);
        tick();
        chk("illegal_zero_data", data_out, 64'h0);
        chk("illegal_valid", 64'(out_valid), 64'd1);
        chk("illegal_sel_err", 64'(sel_err), 64'd1);
        chk("hold_illegal_data", h_data_out, 64'h22);
        chk("hold_illegal_valid", 64'(h_out_valid), 64'd1);
        chk("hold_illegal_sel_err", 64'(h_sel_err), 64'd1);
`ifdef FWD_MUX_ERR_CNT_EN
        chk("err_cnt_one", 64'(err_cnt), 64'd1);
`endif
        drive(1'b0, 2'd0);
        tick();
        chk("illegal_drain", 64'(out_valid), 64'd0);

        // flush drops a same-cycle input
        drive(1'b1, 2'd1); exp_q.push_back(64'h22);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'd0);
        tick();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_data", data_out, 64'h22);
        chk("flush_sel_err", 64'(sel_err), 64'd1);
        chk("flush_h_sel_err", 64'(h_sel_err), 64'd1);
`ifdef FWD_MUX_ERR_CNT_EN
        chk("flush_err_cnt", 64'(err_cnt), 64'd1);
`endif
        flush = 1'b0;
        drive(1'b0, 2'd0);
        tick();
        chk("flush_stays_clear", 64'(out_valid), 64'd0);

`ifdef FWD_MUX_ERR_CNT_EN
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd3); exp_q.push_back(64'h0);
            tick();
        end
        drive(1'b0, 2'd0);
        tick();
        chk("err_cnt_sat", 64'(err_cnt), 64'd255);
        chk("h_err_cnt_sat", 64'(h_err_cnt), 64'd255);
`endif

        // reset in the middle of a held transfer
        out_ready = 1'b0;
        drive(1'b1, 2'd2);
        tick();
        chk("pre_rst_data", data_out, 64'h33);
        drive(1'b0, 2'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_data", data_out, 64'd0);
        chk("midrst_sel_err", 64'(sel_err), 64'd0);
        chk("midrst_h_data", h_data_out, 64'd0);
        chk("midrst_h_sel_err", 64'(h_sel_err), 64'd0);
`ifdef FWD_MUX_ERR_CNT_EN
        chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
`endif
        tick();
        rst_n = 1'b1;
        chk("rerst_in_ready", 64'(in_ready), 64'd1);

        out_ready = 1'b1;
        drive(1'b1, 2'd0); exp_q.push_back(64'h11);
        tick();
        drive(1'b0, 2'd0);
        tick();
        chk("final_drain", 64'(out_valid), 64'd0);
        chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
